ysyx_23060240_dmem_responder: RTL and testbench

- Synthesizable data-memory responder: the target end of the load/store path driven by the core's memory stage.
- Accepts one load or store request at a time over a valid/ready request channel.
- Performs the access against an internal word array after a programmable latency.
- Returns load data, already lane-extracted and sign/zero-extended, or a store acknowledge over a valid/ready response channel.

---
 rtl/ysyx_23060240_dmem_responder_pkg.sv | 28 ++
 rtl/ysyx_23060240_dmem_lane.sv | 66 ++++++
 rtl/ysyx_23060240_dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_ysyx_23060240_dmem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060240_dmem_responder_pkg.sv
// Shared encodings and types for the data-memory load/store path.
// Also used by the core's memory-stage decode.
package ysyx_23060240_dmem_responder_pkg;

  localparam logic [2:0] RdLb  = 3'b000;
  localparam logic [2:0] RdLh  = 3'b001;
  localparam logic [2:0] RdLw  = 3'b010;
  localparam logic [2:0] RdLbu = 3'b100;
  localparam logic [2:0] RdLhu = 3'b101;

  localparam logic [1:0] WrSb = 2'b00;
  localparam logic [1:0] WrSh = 2'b01;
  localparam logic [1:0] WrSw = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } dmem_rsp_t;

  localparam dmem_rsp_t RspErr = '{err: 1'b1, rdata: 32'h0};

endpackage

// File: rtl/ysyx_23060240_dmem_lane.sv
// Byte-lane logic: store enables/replicated data, load extraction/extension,
// and decode/alignment fault detection.
module ysyx_23060240_dmem_lane
  import ysyx_23060240_dmem_responder_pkg::*;
(
  input  logic        wr_i,
  input  logic [2:0]  rd_ctrl_i,
  input  logic [1:0]  wr_ctrl_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {lane_i, 3'b000};
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = 32'h0;
    err_o   = 1'b0;
    if (wr_i) begin
      case (wr_ctrl_i)
        WrSb: begin
          be_o    = 4'b0001 << lane_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        WrSh: begin
          be_o    = 4'b0011 << lane_i;
          wdata_o = {2{wdata_i[15:0]}};
          err_o   = lane_i[0];
        end
        WrSw: begin
          be_o  = 4'b1111;
          err_o = |lane_i;
        end
        default: err_o = 1'b1;
      endcase
      if (err_o) be_o = 4'b0000;
    end else begin
      case (rd_ctrl_i)
        RdLb:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
        RdLbu: rdata_o = {24'h0, shifted[7:0]};
        RdLh: begin
          rdata_o = {{16{shifted[15]}}, shifted[15:0]};
          err_o   = lane_i[0];
        end
        RdLhu: begin
          rdata_o = {16'h0, shifted[15:0]};
          err_o   = lane_i[0];
        end
        RdLw: begin
          rdata_o = word_i;
          err_o   = |lane_i;
        end
        default: err_o = 1'b1;
      endcase
      if (err_o) rdata_o = 32'h0;
    end
  end

endmodule

// File: rtl/ysyx_23060240_dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency,
// valid/ready request and response channels over an internal word array.
module ysyx_23060240_dmem_responder
  import ysyx_23060240_dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_rd_ctrl,
  input  logic [1:0]  req_wr_ctrl,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [31:0] Span = 32'(DEPTH * 4);

  dmem_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      rd_ctrl_q, rd_ctrl_d;
  logic [1:0]      wr_ctrl_q, wr_ctrl_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem_q [DEPTH];

  logic [31:0]     off;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic [31:0]     ld_data;
  logic            lane_err;
  logic            acc_err;
  logic            fire;
  logic            commit;
  dmem_rsp_t       rsp_new;

  assign off      = addr_q - BASE;
  assign in_range = off < Span;
  assign idx      = off[AW+1:2];
  assign acc_err  = !in_range || lane_err;
  assign fire     = (state_q == StWait) && (cnt_q == '0);
  assign commit   = fire && wr_q && !acc_err && rst_n;

  assign req_ready = (state_q == StIdle) && rst_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  ysyx_23060240_dmem_lane u_lane (
    .wr_i      (wr_q),
    .rd_ctrl_i (rd_ctrl_q),
    .wr_ctrl_i (wr_ctrl_q),
    .lane_i    (off[1:0]),
    .wdata_i   (wdata_q),
    .word_i    (mem_q[idx]),
    .be_o      (be),
    .wdata_o   (wdata_rep),
    .rdata_o   (ld_data),
    .err_o     (lane_err)
  );

  // Every accept passes through StWait; cnt = LAT-1 makes the edge entering
  // StResp land exactly LAT edges after the accept, LAT==1 included.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    rd_ctrl_d   = rd_ctrl_q;
    wr_ctrl_d   = wr_ctrl_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (acc_err) begin
      rsp_new = RspErr;
    end else begin
      rsp_new = '{err: 1'b0, rdata: (wr_q ? 32'h0 : ld_data)};
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          wr_d      = req_wr;
          addr_d    = req_addr;
          rd_ctrl_d = req_rd_ctrl;
          wr_ctrl_d = req_wr_ctrl;
          wdata_d   = req_wdata;
          cnt_d     = CntW'(LAT - 1);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = rsp_new.err;
          rsp_rdata_d = rsp_new.rdata;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= 32'h0;
      rd_ctrl_q   <= 3'b000;
      wr_ctrl_q   <= 2'b00;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      rd_ctrl_q   <= rd_ctrl_d;
      wr_ctrl_q   <= wr_ctrl_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_dmem_responder.sv
// Self-checking bench: directed cases plus randomized traffic against a
// byte-addressed reference model of the memory.
module tb_ysyx_23060240_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [2:0]  req_rd_ctrl;
  logic [1:0]  req_wr_ctrl;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_bytes [int unsigned];

  always #5 clk = ~clk;

  ysyx_23060240_dmem_responder #(
    .DEPTH (DEPTH),
    .BASE  (BASE),
    .LAT   (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_rd_ctrl (req_rd_ctrl),
    .req_wr_ctrl (req_wr_ctrl),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size/signedness from the ctrl code.
  function automatic void model(input logic wr, input logic [31:0] addr, input logic [2:0] rc,
                                input logic [1:0] wc, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd, output logic known);
    logic [31:0] off;
    int unsigned size;
    logic        sgn;
    logic [31:0] v;
    off   = addr - BASE;
    err   = 1'b0;
    rd    = 32'h0;
    known = 1'b1;
    size  = 1;
    sgn   = 1'b0;
    v     = 32'h0;
    if (wr) begin
      case (wc)
        2'd0: size = 1;
        2'd1: size = 2;
        2'd2: size = 4;
        default: err = 1'b1;
      endcase
    end else begin
      case (rc)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: err = 1'b1;
      endcase
    end
    if (off >= DEPTH * 4) err = 1'b1;
    if (off % size != 0) err = 1'b1;
    if (err) return;
    for (int b = 0; b < int'(size); b++) begin
      if (wr) begin
        ref_bytes[off + b] = wd[8*b +: 8];
      end else if (ref_bytes.exists(off + b)) begin
        v[8*b +: 8] = ref_bytes[off + b];
      end else begin
        known = 1'b0;
      end
    end
    if (!wr) begin
      if (size == 1) rd = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
      else if (size == 2) rd = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
      else rd = v;
    end
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic do_txn(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] rc, input logic [1:0] wc, input logic [31:0] wd,
                        input int bp, output logic [31:0] got_rd, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        known;
    int          w;
    int          lat;
    req_wr      = wr;
    req_addr    = addr;
    req_rd_ctrl = rc;
    req_wr_ctrl = wc;
    req_wdata   = wd;
    req_valid   = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) check_eq({tag, "_ready_timeout"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    model(wr, addr, rc, wc, wd, exp_err, exp_rd, known);
    // Junk request while busy must be ignored.
    req_wr    = 1'b1;
    req_addr  = BASE + 32'h10;
    req_wr_ctrl = 2'd2;
    req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_latency"}, lat, LAT);
    got_rd  = rsp_rdata;
    got_err = rsp_err;
    check_eq({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    if (known) check_eq({tag, "_rdata"}, rsp_rdata, exp_rd);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_bp_valid"}, {31'h0, rsp_valid}, 32'h1);
      check_eq({tag, "_bp_rdata"}, rsp_rdata, got_rd);
      check_eq({tag, "_bp_ready"}, {31'h0, req_ready}, 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq({tag, "_post_valid"}, {31'h0, rsp_valid}, 32'h0);
    check_eq({tag, "_post_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_valid"}, {31'h0, rsp_valid}, 32'h0);
    check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
    check_eq({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
    check_eq({tag, "_ready"}, {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq({tag, "_ready_rel"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_wr = 1'b0;
    req_addr = 32'h0; req_rd_ctrl = 3'd0; req_wr_ctrl = 2'd0; req_wdata = 32'h0;
    #3;
    check_eq("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_err", {31'h0, rsp_err}, 32'h0);
    check_eq("rst_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_ready", {31'h0, req_ready}, 32'h1);

    do_txn("sw", 1, BASE + 32'h10, 3'd0, 2'd2, 32'hDEADBEEF, 0, rd, er);
    check_eq("sw_ack", {er, rd[30:0]}, 32'h0);
    do_txn("lw", 0, BASE + 32'h10, 3'd2, 2'd0, 32'h0, 0, rd, er);
    check_eq("lw_dir", rd, 32'hDEADBEEF);
    do_txn("lb", 0, BASE + 32'h13, 3'd0, 2'd0, 32'h0, 0, rd, er);
    check_eq("lb_dir", rd, 32'hFFFFFFDE);
    do_txn("lbu", 0, BASE + 32'h13, 3'd4, 2'd0, 32'h0, 0, rd, er);
    check_eq("lbu_dir", rd, 32'h000000DE);
    do_txn("lh", 0, BASE + 32'h12, 3'd1, 2'd0, 32'h0, 0, rd, er);
    check_eq("lh_dir", rd, 32'hFFFFDEAD);
    do_txn("lhu", 0, BASE + 32'h10, 3'd5, 2'd0, 32'h0, 0, rd, er);
    check_eq("lhu_dir", rd, 32'h0000BEEF);
    do_txn("sb", 1, BASE + 32'h11, 3'd0, 2'd0, 32'h12, 0, rd, er);
    do_txn("lw_sb", 0, BASE + 32'h10, 3'd2, 2'd0, 32'h0, 0, rd, er);
    check_eq("lw_sb_dir", rd, 32'hDEAD12EF);
    do_txn("sh", 1, BASE + 32'h12, 3'd0, 2'd1, 32'h3456, 0, rd, er);
    do_txn("lw_sh", 0, BASE + 32'h10, 3'd2, 2'd0, 32'h0, 0, rd, er);
    check_eq("lw_sh_dir", rd, 32'h345612EF);

    do_txn("lw_mis", 0, BASE + 32'h2, 3'd2, 2'd0, 32'h0, 0, rd, er);
    check_eq("lw_mis_dir", {er, rd[30:0]}, 32'h8000_0000);
    do_txn("sw_init0", 1, BASE, 3'd0, 2'd2, 32'hA5A5_0001, 0, rd, er);
    do_txn("sw_oor", 1, BASE + DEPTH * 4, 3'd0, 2'd2, 32'h5555_5555, 0, rd, er);
    check_eq("sw_oor_dir", {31'h0, er}, 32'h1);
    do_txn("lw_oor_chk", 0, BASE, 3'd2, 2'd0, 32'h0, 0, rd, er);
    check_eq("lw_oor_chk_dir", rd, 32'hA5A5_0001);
    do_txn("wc11", 1, BASE + 32'h10, 3'd0, 2'd3, 32'h0, 0, rd, er);
    check_eq("wc11_dir", {31'h0, er}, 32'h1);
    do_txn("lw_wc11", 0, BASE + 32'h10, 3'd2, 2'd0, 32'h0, 0, rd, er);
    check_eq("lw_wc11_dir", rd, 32'h345612EF);

    do_txn("bp", 0, BASE + 32'h10, 3'd2, 2'd0, 32'h0, 5, rd, er);

    // Reset while a store is waiting to commit.
    do_txn("sw20", 1, BASE + 32'h20, 3'd0, 2'd2, 32'h1122_3344, 0, rd, er);
    req_wr = 1'b1; req_addr = BASE + 32'h20; req_wr_ctrl = 2'd2;
    req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    reset_check("rst_wait");
    do_txn("lw20", 0, BASE + 32'h20, 3'd2, 2'd0, 32'h0, 0, rd, er);
    check_eq("lw20_dir", rd, 32'h1122_3344);

    // Reset while a response is held.
    req_wr = 1'b0; req_addr = BASE + 32'h10; req_rd_ctrl = 3'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT) begin
      @(posedge clk); #1;
    end
    check_eq("resp_held_valid", {31'h0, rsp_valid}, 32'h1);
    reset_check("rst_resp");

    for (int i = 0; i < 16; i++) begin
      do_txn("fill", 1, BASE + 32'(4 * i), 3'd0, 2'd2, $urandom, 0, rd, er);
    end
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [2:0]  rc;
      logic [1:0]  wc;
      int          sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) a = BASE - 32'h4;
      else if (sel == 1) a = BASE + DEPTH * 4 + $urandom_range(0, 15);
      else if (sel == 2) a = $urandom;
      else a = BASE + $urandom_range(0, 63);
      rc = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (rc == 3'd0 && $urandom_range(0, 1) == 1) rc = 3'd4;
      if (rc == 3'd1 && $urandom_range(0, 1) == 1) rc = 3'd5;
      wc = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_txn("rnd", 1'($urandom), a, rc, wc, $urandom, $urandom_range(0, 2), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
